// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned WIDTHxWIDTH shift-add multiplier.
// Ports: clk, rst_n, start, op_a, op_b in; busy, done, product out;
// alu_* outputs drive a shared adder; alu_out/alu_c_out return its sum.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               alu_enable,
  output logic [3:0]         alu_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_c_in,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_c_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               last;
  logic [2*WIDTH-1:0] shifted;

  assign last = (count == CW'(WIDTH - 1));

  // Carry-out lands in the top bit; the LSB of acc_lo drops off.
  assign shifted = {alu_c_out, alu_out, acc_lo[WIDTH-1:1]};

  assign alu_sel  = 4'b0000;
  assign alu_c_in = 1'b0;
  assign alu_a    = acc_hi;
  assign alu_b    = acc_lo[0] ? mcand : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    alu_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        alu_enable = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            acc_hi <= '0;
            acc_lo <= op_b;
            count  <= '0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= shifted;
          count <= count + CW'(1);
          if (last) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule
